// File: rtl/alu_mac_sequencer.sv
// alu_mac_sequencer: dot-product controller driving a registered 16-bit ALU (MUL then ADD per pair).
// Define ALU_MAC_ZERO_SKIP_EN to retire pairs with a zero operand in one cycle without ALU traffic.
module alu_mac_sequencer #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic [3:0]        alu_control,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   input  logic [DATA_W-1:0] alu_out,
   output logic              busy,
   output logic              result_valid,
   output logic [DATA_W-1:0] result,
   output logic              result_zero
);
   typedef enum logic [2:0] {IDLE, FETCH, MUL_ISSUE, MUL_WAIT, ADD_ISSUE, ADD_WAIT, DONE} state_t;
   localparam logic [3:0] NOP = 4'd0, MUL = 4'd1, ADD = 4'd2;
   state_t            state_q, state_d;
   logic [3:0]        ctl_q, ctl_d;
   logic [DATA_W-1:0] in1_q, in1_d, in2_q, in2_d, acc_q, acc_d, res_q, res_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              rz_q, rz_d, xfer, last;
   assign op_ready     = state_q == FETCH;
   assign busy         = state_q != IDLE;
   assign result_valid = state_q == DONE;
   assign alu_control  = ctl_q;
   assign alu_in1      = in1_q;
   assign alu_in2      = in2_q;
   assign result       = res_q;
   assign result_zero  = rz_q;
   assign xfer         = op_valid && op_ready;
   assign last         = cnt_q == LEN_W'(1);
   always_comb begin
      state_d = state_q;
      ctl_d   = NOP;
      in1_d   = in1_q;
      in2_d   = in2_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      case (state_q)
         IDLE: if (start) begin
            acc_d   = '0;
            cnt_d   = len;
            res_d   = len == '0 ? '0 : res_q;
            state_d = len == '0 ? DONE : FETCH;
         end
         FETCH: if (xfer) begin
`ifdef ALU_MAC_ZERO_SKIP_EN
            if (op_a == '0 || op_b == '0) begin
               cnt_d   = cnt_q - 1'b1;
               res_d   = last ? acc_q : res_q;
               state_d = last ? DONE : FETCH;
            end else begin
               state_d = MUL_ISSUE;
               ctl_d   = MUL;
               in1_d   = op_a;
               in2_d   = op_b;
            end
`else
            state_d = MUL_ISSUE;
            ctl_d   = MUL;
            in1_d   = op_a;
            in2_d   = op_b;
`endif
         end
         MUL_ISSUE: state_d = MUL_WAIT;
         MUL_WAIT: begin
            state_d = ADD_ISSUE;
            ctl_d   = ADD;
            in1_d   = acc_q;
            in2_d   = alu_out;
         end
         ADD_ISSUE: state_d = ADD_WAIT;
         ADD_WAIT: begin
            acc_d   = alu_out;
            cnt_d   = cnt_q - 1'b1;
            res_d   = last ? alu_out : res_q;
            state_d = last ? DONE : FETCH;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // DONE is only ever entered from another state, so this fires once per result
      rz_d = state_d == DONE ? res_d == '0 : rz_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ctl_q   <= NOP;
         in1_q   <= '0;
         in2_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         rz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ctl_q   <= ctl_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         rz_q    <= rz_d;
      end
   end
endmodule

// File: tb/tb_alu_mac_sequencer.sv
// tb_alu_mac_sequencer: random and directed dot products against a sum-of-products reference model.
module tb_alu_mac_sequencer;
   logic        clk = 0, rst = 1, start = 0, op_valid = 0;
   logic [7:0]  len = 0;
   logic [15:0] op_a = 0, op_b = 0, alu_in1, alu_in2, alu_out, result;
   logic [3:0]  alu_control;
   logic        op_ready, busy, result_valid, result_zero;
   int          checks = 0, failures = 0;
   logic [15:0] pa [16], pb [16];
   int          st [16];
`ifdef ALU_MAC_ZERO_SKIP_EN
   localparam bit SKIP = 1;
`else
   localparam bit SKIP = 0;
`endif
   always #5 clk = ~clk;
   alu_mac_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b), .alu_control(alu_control), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_out(alu_out), .busy(busy), .result_valid(result_valid), .result(result),
      .result_zero(result_zero)
   );
   // registered ALU the sequencer is meant to drive
   always_ff @(posedge clk) begin
      logic [31:0] p;
      p = alu_in1 * alu_in2;
      alu_out <= rst ? 16'd0 : alu_control == 4'd1 ? p[15:0] : alu_control == 4'd2 ? 16'(alu_in1 + alu_in2) : alu_out;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctl"}, alu_control, 0);
      chk({tag, "_in1"}, alu_in1, 0);
      chk({tag, "_in2"}, alu_in2, 0);
      chk({tag, "_res"}, result, 0);
      chk({tag, "_flags"}, {busy, op_ready, result_valid, result_zero}, 0);
   endtask
   task automatic set_pair(input int i, input logic [15:0] a, input logic [15:0] b, input int s);
      pa[i] = a;
      pb[i] = b;
      st[i] = s;
   endtask
   task automatic run_dot(input int n, input int rst_at);
      int idx = 0, stl = 0, m = 0, muls = 0, adds = 0, bad = 0, exp_cyc = 0, exp_mul = 0;
      logic [15:0] exp_sum = 0;
      logic [31:0] prod;
      bit done = 0, zero;
      for (int i = 0; i < n; i++) begin
         zero = pa[i] == 0 || pb[i] == 0;
         prod = pa[i] * pb[i];
         exp_sum += prod[15:0];
         exp_cyc += st[i] + ((SKIP && zero) ? 1 : 5);
         exp_mul += (SKIP && zero) ? 0 : 1;
      end
      @(negedge clk);
      start = 1;
      len = 8'(n);
      @(posedge clk);
      #1 start = 0;
      stl = n > 0 ? st[0] : 0;
      for (m = 0; m < 400; m++) begin
         @(negedge clk);
         if (m == rst_at) begin
            rst = 1;
            op_valid = 0;
            @(posedge clk);
            #1 check_reset_outputs("rst_mid");
            rst = 0;
            return;
         end
         if (alu_control == 4'd1) begin
            muls++;
            if (idx == 0 || alu_in1 !== pa[idx-1] || alu_in2 !== pb[idx-1]) bad++;
         end
         if (alu_control == 4'd2) adds++;
         if (alu_control > 4'd2) bad++;
         if (result_valid) begin
            done = 1;
            break;
         end
         if (!busy) bad++;
         if (op_ready && stl > 0) begin
            stl--;
            op_valid = 0;
            start = 1;
            if (alu_control != 4'd0) bad++;
         end else if (op_ready) begin
            op_valid = 1;
            op_a = pa[idx];
            op_b = pb[idx];
            start = 0;
            idx++;
            stl = idx < n ? st[idx] : 0;
         end else begin
            op_valid = 1'($urandom);
            op_a = 16'($urandom);
            op_b = 16'($urandom);
            start = 0;
         end
         @(posedge clk);
         #1;
      end
      op_valid = 0;
      start = 0;
      chk("done_seen", done, 1);
      chk("cycles", m, exp_cyc);
      chk("result", result, exp_sum);
      chk("result_zero", result_zero, exp_sum == 0);
      chk("ready_at_done", op_ready, 0);
      chk("mul_count", muls, exp_mul);
      chk("add_count", adds, exp_mul);
      chk("protocol", bad, 0);
      @(posedge clk);
      #1 chk("pulse_width", result_valid, 0);
      chk("idle_after", busy, 0);
      chk("result_hold", result, exp_sum);
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("reset");
      rst = 0;
      set_pair(0, 2, 3, 0); set_pair(1, 4, 5, 0); set_pair(2, 1, 7, 0);
      run_dot(3, -1);
      set_pair(0, 300, 300, 0);
      run_dot(1, -1);
      set_pair(0, 65535, 1, 0); set_pair(1, 1, 1, 0);
      run_dot(2, -1);
      run_dot(0, -1);
      set_pair(0, 9, 11, 0); set_pair(1, 13, 2, 3);
      run_dot(2, -1);
      set_pair(0, 5, 5, 0); set_pair(1, 6, 6, 0); set_pair(2, 7, 7, 0); set_pair(3, 8, 8, 0);
      run_dot(4, 2);
      set_pair(0, 6, 7, 0);
      run_dot(1, -1);
      set_pair(0, 0, 9, 0); set_pair(1, 3, 3, 0); set_pair(2, 5, 0, 0);
      run_dot(3, -1);
      for (int r = 0; r < 20; r++) begin
         int n;
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++)
            set_pair(i, $urandom_range(0, 3) == 0 ? 16'd0 : 16'($urandom),
                     $urandom_range(0, 3) == 0 ? 16'd0 : 16'($urandom),
                     $urandom_range(0, 2) == 0 ? int'($urandom_range(1, 2)) : 0);
         run_dot(n, -1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
